fft_input_loader: RTL and testbench

- Front-end loader for the FFT working memory. It is the write-side counterpart of the FFT output stage.
- Accepts one natural-order input sample per cycle over a valid/ready stream and pairs consecutive samples.
- Writes each pair into the dual-write-port sample RAM at bit-reversed addresses, ready for an in-place decimation-in-time FFT.
- Pulses done when a full N-point frame is resident, so the FFT core can start.

---
 rtl/fft_input_loader_if.sv | 26 ++
 rtl/fft_input_loader.sv | 133 +++++++++++++
 tb/tb_fft_input_loader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_input_loader_if.sv
// Interface between the FFT input loader and its neighbours.
// It carries the natural-order sample stream and the dual-port RAM write bus.
interface fft_input_loader_if #(
  parameter int word_size     = 16,
  parameter int address_width = 5
);
  logic [word_size-1:0]     in_samp;
  logic                     in_valid;
  logic                     in_ready;
  logic                     wr_en;
  logic [address_width-1:0] wr_addr1;
  logic [address_width-1:0] wr_addr2;
  logic [word_size-1:0]     wr_samp1;
  logic [word_size-1:0]     wr_samp2;

  // master: sample source / RAM observer side; slave: the loader itself
  modport master (
    output in_samp, in_valid,
    input  in_ready, wr_en, wr_addr1, wr_addr2, wr_samp1, wr_samp2
  );

  modport slave (
    input  in_samp, in_valid,
    output in_ready, wr_en, wr_addr1, wr_addr2, wr_samp1, wr_samp2
  );
endinterface

// File: rtl/fft_input_loader.sv
// Loads one N-point frame of natural-order samples into the FFT sample RAM,
// writing even/odd sample pairs at bit-reversed addresses.
//
// Handshake: a sample is consumed on a rising edge where in_valid && in_ready;
// in_ready is high exactly while in LOAD, and in_valid has no effect otherwise.
module fft_input_loader #(
  parameter int N             = 32,
  parameter int word_size     = 16,
  parameter int address_width = $clog2(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  fft_input_loader_if.slave   bus,
  output logic                busy,
  output logic                done,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [address_width-1:0] LAST = address_width'(N - 1);

  function automatic logic [address_width-1:0] bitrev(input logic [address_width-1:0] a);
    logic [address_width-1:0] r;
    r = '0;
    for (int i = 0; i < address_width; i++) r[i] = a[address_width-1-i];
    return r;
  endfunction

  state_t                   state_q, state_d;
  logic [address_width-1:0] count_q, count_d;
  logic [word_size-1:0]     hold_q, hold_d;
  logic                     wr_en_q, wr_en_d;
  logic [address_width-1:0] addr1_q, addr1_d;
  logic [address_width-1:0] addr2_q, addr2_d;
  logic [word_size-1:0]     samp1_q, samp1_d;
  logic [word_size-1:0]     samp2_q, samp2_d;
  logic                     ready_q, ready_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     accept;

  assign accept = (state_q == LOAD) && bus.in_valid;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hold_d  = hold_q;
    wr_en_d = 1'b0;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    samp1_d = samp1_q;
    samp2_d = samp2_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          if (!count_q[0]) begin
            hold_d = bus.in_samp;
          end else begin
            // The even partner index is count with its LSB cleared.
            wr_en_d = 1'b1;
            addr1_d = bitrev({count_q[address_width-1:1], 1'b0});
            addr2_d = bitrev(count_q);
            samp1_d = hold_q;
            samp2_d = bus.in_samp;
          end
          if (count_q == LAST) begin
            state_d = DONE;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flag outputs are decoded from the next state so they are registered.
    ready_d = (state_d == LOAD);
    busy_d  = (state_d == LOAD);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      hold_q  <= '0;
      wr_en_q <= 1'b0;
      addr1_q <= '0;
      addr2_q <= '0;
      samp1_q <= '0;
      samp2_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hold_q  <= hold_d;
      wr_en_q <= wr_en_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      samp1_q <= samp1_d;
      samp2_q <= samp2_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.in_ready = ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr1 = addr1_q;
  assign bus.wr_addr2 = addr2_q;
  assign bus.wr_samp1 = samp1_q;
  assign bus.wr_samp2 = samp2_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader: an N=8 and an N=32 instance share the
// clock and reset; sel chooses which one the stimulus and observation target.
module tb_fft_input_loader;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        valid;
  logic        start;
  logic [15:0] samp;

  int tests_run;
  int tests_failed;

  fft_input_loader_if #(.word_size(16), .address_width(3)) if8 ();
  fft_input_loader_if #(.word_size(16), .address_width(5)) if32 ();

  logic       start8, start32, busy8, busy32, done8, done32;
  logic [1:0] dbg8, dbg32;

  assign if8.in_samp   = samp;
  assign if32.in_samp  = samp;
  assign if8.in_valid  = valid & ~sel;
  assign if32.in_valid = valid & sel;
  assign start8        = start & ~sel;
  assign start32       = start & sel;

  fft_input_loader #(.N(8), .word_size(16)) dut8 (
    .clk(clk), .reset(rst_n), .start(start8), .bus(if8.slave),
    .busy(busy8), .done(done8), .dbg_state_o(dbg8)
  );

  fft_input_loader #(.N(32), .word_size(16)) dut32 (
    .clk(clk), .reset(rst_n), .start(start32), .bus(if32.slave),
    .busy(busy32), .done(done32), .dbg_state_o(dbg32)
  );

  logic        o_ready, o_wr_en, o_busy, o_done;
  logic [1:0]  o_state;
  logic [4:0]  o_a1, o_a2;
  logic [15:0] o_s1, o_s2;

  assign o_ready = sel ? if32.in_ready : if8.in_ready;
  assign o_wr_en = sel ? if32.wr_en    : if8.wr_en;
  assign o_busy  = sel ? busy32        : busy8;
  assign o_done  = sel ? done32        : done8;
  assign o_state = sel ? dbg32         : dbg8;
  assign o_a1    = sel ? if32.wr_addr1 : {2'b00, if8.wr_addr1};
  assign o_a2    = sel ? if32.wr_addr2 : {2'b00, if8.wr_addr2};
  assign o_s1    = sel ? if32.wr_samp1 : if8.wr_samp1;
  assign o_s2    = sel ? if32.wr_samp2 : if8.wr_samp2;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected bit-reversed even addresses for the four N=8 pairs
  logic [4:0] exp8_a1 [4];
  initial begin
    exp8_a1[0] = 5'd0; exp8_a1[1] = 5'd2; exp8_a1[2] = 5'd1; exp8_a1[3] = 5'd3;
  end

  logic [41:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] bitrev5(input logic [4:0] a);
    return {a[0], a[1], a[2], a[3], a[4]};
  endfunction

  // driver: present inputs for one edge, then return 1 time unit after it
  task automatic step(input logic v, input logic [15:0] d, input logic s);
    valid = v;
    samp  = d;
    start = s;
    @(posedge clk);
    #1;
    valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, o_ready, 0);
    check({tag, "_wr_en"}, o_wr_en, 0);
    check({tag, "_busy"},  o_busy,  0);
    check({tag, "_done"},  o_done,  0);
    check({tag, "_a1"},    o_a1,    0);
    check({tag, "_a2"},    o_a2,    0);
    check({tag, "_s1"},    o_s1,    0);
    check({tag, "_s2"},    o_s2,    0);
  endtask

  task automatic check_write(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                             input logic [15:0] s1, input logic [15:0] s2);
    check({tag, "_wr_en"}, o_wr_en, 1);
    check({tag, "_a1"},    o_a1,    a1);
    check({tag, "_a2"},    o_a2,    a2);
    check({tag, "_s1"},    o_s1,    s1);
    check({tag, "_s2"},    o_s2,    s2);
  endtask

  // full N=8 frame starting at sample value base, optionally with 2-cycle gaps
  task automatic load_frame8(input string tag, input logic [15:0] base, input bit gaps);
    step(0, 16'h0, 1);
    check({tag, "_start_ready"}, o_ready, 1);
    check({tag, "_start_busy"},  o_busy,  1);
    check({tag, "_start_state"}, o_state, 1);
    for (int p = 0; p < 4; p++) begin
      step(1, base + 16'(2 * p), 0);
      check({tag, "_even_nowr"}, o_wr_en, 0);
      if (gaps) begin
        step(0, 16'hDEAD, 0);
        check({tag, "_gap1_nowr"}, o_wr_en, 0);
        step(0, 16'hBEEF, 0);
        check({tag, "_gap2_nowr"}, o_wr_en, 0);
        check({tag, "_gap_ready"}, o_ready, 1);
      end
      step(1, base + 16'(2 * p + 1), 0);
      check_write({tag, "_pair"}, exp8_a1[p], exp8_a1[p] + 5'd4,
                  base + 16'(2 * p), base + 16'(2 * p + 1));
      check({tag, "_done_flag"}, o_done, (p == 3) ? 1 : 0);
      check({tag, "_busy_flag"}, o_busy, (p == 3) ? 0 : 1);
      check({tag, "_ready_flag"}, o_ready, (p == 3) ? 0 : 1);
    end
    step(0, 16'h0, 0);
    check({tag, "_after_done"},  o_done,  0);
    check({tag, "_after_wr_en"}, o_wr_en, 0);
    check({tag, "_after_ready"}, o_ready, 0);
    check({tag, "_hold_a1"},     o_a1,    3);
    check({tag, "_hold_s2"},     o_s2,    base + 16'd7);
  endtask

  int writes32;
  int dones32;
  logic [41:0] e;

  initial begin
    tests_run = 0;
    tests_failed = 0;
    sel   = 1'b0;
    valid = 1'b0;
    start = 1'b0;
    samp  = '0;
    rst_n = 1'b0;

    // reset state, then idle with in_valid but no start
    #2;
    check_zero("rst0");
    #5 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1, 16'h00AA, 0);
      check("idle_ready", o_ready, 0);
      check("idle_wr_en", o_wr_en, 0);
      check("idle_busy",  o_busy,  0);
    end

    // back-to-back frame, then the same with gaps around each pair
    load_frame8("b2b", 16'h0010, 0);
    load_frame8("gap", 16'h0010, 1);

    // start during LOAD (count 5) and during DONE is ignored
    step(0, 16'h0, 1);
    for (int k = 0; k < 8; k++) begin
      step(1, 16'h0030 + 16'(k), (k == 5) ? 1'b1 : 1'b0);
      if (k % 2 == 1)
        check_write("restart_pair", exp8_a1[k / 2], exp8_a1[k / 2] + 5'd4,
                    16'h0030 + 16'(k - 1), 16'h0030 + 16'(k));
    end
    check("restart_done", o_done, 1);
    step(0, 16'h0, 1);
    check("done_start_busy",  o_busy,  0);
    check("done_start_ready", o_ready, 0);
    check("done_start_done",  o_done,  0);
    for (int i = 0; i < 2; i++) begin
      step(1, 16'h0099, 0);
      check("no_frame_ready", o_ready, 0);
      check("no_frame_wr_en", o_wr_en, 0);
    end
    load_frame8("fresh", 16'h0040, 0);

    // reset after 5 accepts aborts the frame without writing sample 4
    step(0, 16'h0, 1);
    for (int k = 0; k < 5; k++) step(1, 16'h0050 + 16'(k), 0);
    check("pre_rst_busy", o_busy, 1);
    check("pre_rst_a1",   o_a1,   2);
    #3 rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    step(1, 16'h0077, 0);
    check("rst_low_wr_en", o_wr_en, 0);
    #4 rst_n = 1'b1;
    step(1, 16'h0077, 0);
    check("rst_rel_ready", o_ready, 0);
    check("rst_rel_wr_en", o_wr_en, 0);
    load_frame8("post_rst", 16'h0060, 0);

    // N=32 full frame with in_samp = k, scoreboarded
    sel = 1'b1;
    writes32 = 0;
    dones32 = 0;
    step(0, 16'h0, 1);
    check("n32_start_ready", o_ready, 1);
    for (int k = 0; k < 32; k++) begin
      if (k % 2 == 1)
        exp_q.push_back({bitrev5(5'(k - 1)), bitrev5(5'(k)), 16'(k - 1), 16'(k)});
      step(1, 16'(k), 0);
      if (o_wr_en) begin
        writes32++;
        check("n32_q_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("n32_a1", o_a1, e[41:37]);
          check("n32_a2", o_a2, e[36:32]);
          check("n32_s1", o_s1, e[31:16]);
          check("n32_s2", o_s2, e[15:0]);
        end
      end
      if (o_done) dones32++;
      if (k == 3) begin
        check("n32_k3_a1", o_a1, 8);
        check("n32_k3_a2", o_a2, 24);
        check("n32_k3_s1", o_s1, 2);
      end
      if (k == 31) begin
        check("n32_k31_a1",   o_a1,   15);
        check("n32_k31_a2",   o_a2,   31);
        check("n32_k31_done", o_done, 1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 16'h0123, 0);
      if (o_wr_en) writes32++;
      if (o_done) dones32++;
    end
    check("n32_writes",   writes32,     16);
    check("n32_dones",    dones32,      1);
    check("n32_q_empty",  exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
